// File: rtl/ir_feed.sv
// ir_feed: prefetch queue between fetch and decode, with cpu_status word injection.
// Optional zero-latency fetch-to-decode bypass when IR_FEED_BYPASS_EN is defined.
module ir_feed #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [15:0] fetch_ir,
  input  logic [15:0] fetch_k,
  output logic        fetch_ready,
  input  logic [15:0] int_ir,
  input  logic [15:0] int_k,
  input  logic        replace_ir,
  input  logic        replace_k,
  input  logic        hold_fetch,
  input  logic        hold_decode,
  output logic        feed_ack,
  output logic [7:0]  ir_low,
  output logic        dec_valid,
  output logic [15:0] dec_ir,
  output logic [15:0] dec_k,
  output logic        dec_injected,
  input  logic        dec_ready,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [15:0]   mem_ir [DEPTH];
  logic [15:0]   mem_k  [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW:0]   occ;

  logic [15:0] head_ir;
  logic [15:0] head_k;
  logic        empty;
  logic        full;
  logic        byp;
  logic        accept;
  logic        push;
  logic        pop;

  assign head_ir = mem_ir[rptr];
  assign head_k  = mem_k[rptr];
  assign empty   = (occ == '0);
  assign full    = (occ == FULL_CNT);

`ifdef IR_FEED_BYPASS_EN
  assign byp = empty & fetch_valid & ~hold_decode & ~replace_ir & ~flush;
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    fetch_ready  = ~full & ~hold_fetch & ~flush;
    dec_valid    = replace_ir | (~hold_decode & ~empty) | byp;
    dec_injected = replace_ir;
    feed_ack     = replace_ir & dec_ready;
    if (replace_ir)
      dec_ir = int_ir;
    else if (byp)
      dec_ir = fetch_ir;
    else
      dec_ir = head_ir;
    if (replace_k)
      dec_k = int_k;
    else if (byp)
      dec_k = fetch_k;
    else
      dec_k = head_k;
    if (byp)
      ir_low = fetch_ir[7:0];
    else if (empty)
      ir_low = '0;
    else
      ir_low = head_ir[7:0];
  end

  // A bypassed word taken by decode is never stored; an injected JSR jump
  // word without replace_k consumes the queued JSR entry holding its K.
  always_comb begin
    accept = dec_valid & dec_ready;
    push   = fetch_valid & fetch_ready & ~(byp & dec_ready);
    pop    = accept & ~empty & (~replace_ir | ~replace_k);
  end

  assign occupancy = occ;

  always_ff @(posedge clk) begin
    if (a_rst || flush) begin
      rptr <= '0;
      wptr <= '0;
      occ  <= '0;
    end else begin
      if (push)
        wptr <= wptr + PTR_ONE;
      if (pop)
        rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   occ <= occ + CNT_ONE;
        2'b01:   occ <= occ - CNT_ONE;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!a_rst && push) begin
      mem_ir[wptr] <= fetch_ir;
      mem_k[wptr]  <= fetch_k;
    end
  end

endmodule

// File: tb/tb_ir_feed.sv
// Scoreboard bench for ir_feed: stimulus queues expected decoder words,
// a negedge monitor pops and compares each accepted word.
module tb_ir_feed;

  logic        clk;
  logic        a_rst;
  logic        flush;
  logic        fetch_valid;
  logic [15:0] fetch_ir;
  logic [15:0] fetch_k;
  logic        fetch_ready;
  logic [15:0] int_ir;
  logic [15:0] int_k;
  logic        replace_ir;
  logic        replace_k;
  logic        hold_fetch;
  logic        hold_decode;
  logic        feed_ack;
  logic [7:0]  ir_low;
  logic        dec_valid;
  logic [15:0] dec_ir;
  logic [15:0] dec_k;
  logic        dec_injected;
  logic        dec_ready;
  logic [2:0]  occupancy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q [$];

  ir_feed #(.DEPTH(4)) dut (
    .clk(clk), .a_rst(a_rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ir(fetch_ir), .fetch_k(fetch_k),
    .fetch_ready(fetch_ready), .int_ir(int_ir), .int_k(int_k),
    .replace_ir(replace_ir), .replace_k(replace_k),
    .hold_fetch(hold_fetch), .hold_decode(hold_decode),
    .feed_ack(feed_ack), .ir_low(ir_low), .dec_valid(dec_valid),
    .dec_ir(dec_ir), .dec_k(dec_k), .dec_injected(dec_injected),
    .dec_ready(dec_ready), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [15:0] ir, input logic [15:0] k, input logic inj);
    exp_q.push_back({ir, k, inj});
  endtask

  always @(negedge clk) begin
    if (!a_rst && dec_valid && dec_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL dec_word: unexpected word got %h/%h inj %b, none expected",
                 dec_ir, dec_k, dec_injected);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({dec_ir, dec_k, dec_injected} !== e) begin
          n_fail++;
          $display("FAIL dec_word: got %h/%h inj %b expected %h/%h inj %b",
                   dec_ir, dec_k, dec_injected, e[32:17], e[16:1], e[0]);
        end
      end
    end
  end

  initial begin
    a_rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_ir = '0; fetch_k = '0;
    int_ir = '0; int_k = '0; replace_ir = 1'b0; replace_k = 1'b0;
    hold_fetch = 1'b0; hold_decode = 1'b0; dec_ready = 1'b0;
    repeat (2) cyc();
    a_rst = 1'b0;
    #2;
    check("rst_dec_valid", 32'(dec_valid), 0);
    check("rst_fetch_ready", 32'(fetch_ready), 1);
    check("rst_occupancy", 32'(occupancy), 0);
    check("rst_feed_ack", 32'(feed_ack), 0);
    check("rst_dec_injected", 32'(dec_injected), 0);
    check("rst_ir_low", 32'(ir_low), 0);

    // Two words streamed with decoder ready
    cyc(); dec_ready = 1'b1; fetch_valid = 1'b1; fetch_ir = 16'h1111; fetch_k = 16'hAAAA;
    expect_word(16'h1111, 16'hAAAA, 1'b0);
    #2;
`ifndef IR_FEED_BYPASS_EN
    check("latency_dec_valid", 32'(dec_valid), 0);
`endif
    check("s1_fetch_ready", 32'(fetch_ready), 1);
    cyc(); fetch_ir = 16'h2222; fetch_k = 16'hBBBB;
    expect_word(16'h2222, 16'hBBBB, 1'b0);
    #2;
`ifndef IR_FEED_BYPASS_EN
    check("s1_occ_mid", 32'(occupancy), 1);
`endif
    cyc(); fetch_valid = 1'b0;
    cyc(); dec_ready = 1'b0; #2;
    check("s1_occ_end", 32'(occupancy), 0);
    check("s1_dec_valid_end", 32'(dec_valid), 0);

    // Fill to full, reject a fifth word, then drain across the pointer wrap
    for (int i = 0; i < 4; i++) begin
      cyc(); fetch_valid = 1'b1; fetch_ir = 16'h30A0 + 16'(i); fetch_k = 16'hC000 + 16'(i);
      expect_word(16'h30A0 + 16'(i), 16'hC000 + 16'(i), 1'b0);
      #2;
      check("fill_fetch_ready", 32'(fetch_ready), 1);
    end
    cyc(); fetch_ir = 16'h5555; fetch_k = 16'h5555; #2;
    check("full_occupancy", 32'(occupancy), 4);
    check("full_fetch_ready", 32'(fetch_ready), 0);
    check("full_ir_low", 32'(ir_low), 32'h0A0);
    cyc(); fetch_valid = 1'b0; dec_ready = 1'b1; #2;
    check("drain_fetch_ready_full", 32'(fetch_ready), 0);
    repeat (3) cyc();
    cyc(); dec_ready = 1'b0; #2;
    check("drain_occupancy", 32'(occupancy), 0);

    // JSR: injected IR+K without pop, then jump word taking the queued K
    cyc(); fetch_valid = 1'b1; fetch_ir = 16'h00F0; fetch_k = 16'h1234;
    cyc(); fetch_valid = 1'b0; replace_ir = 1'b1; replace_k = 1'b1;
    int_ir = 16'h8322; int_k = 16'h0001; dec_ready = 1'b1;
    expect_word(16'h8322, 16'h0001, 1'b1);
    #2;
    check("jsr_feed_ack", 32'(feed_ack), 1);
    check("jsr_dec_injected", 32'(dec_injected), 1);
    check("jsr_ir_low", 32'(ir_low), 32'h0F0);
    cyc(); replace_k = 1'b0; int_ir = 16'h4100;
    expect_word(16'h4100, 16'h1234, 1'b1);
    #2;
    check("jsr_no_pop", 32'(occupancy), 1);
    cyc(); replace_ir = 1'b0; dec_ready = 1'b0; #2;
    check("jsr_popped", 32'(occupancy), 0);

    // Injection on an empty queue
    cyc(); replace_ir = 1'b1; replace_k = 1'b1; int_ir = 16'h9000; int_k = 16'hFFFE; #2;
    check("inj_empty_valid", 32'(dec_valid), 1);
    check("inj_empty_ack0", 32'(feed_ack), 0);
    cyc(); dec_ready = 1'b1;
    expect_word(16'h9000, 16'hFFFE, 1'b1);
    #2;
    check("inj_empty_ack1", 32'(feed_ack), 1);
    cyc(); replace_ir = 1'b0; replace_k = 1'b0; dec_ready = 1'b0; #2;
    check("inj_empty_occ", 32'(occupancy), 0);

    // hold_decode, then flush with a concurrent fetch word
    for (int i = 0; i < 3; i++) begin
      cyc(); fetch_valid = 1'b1; fetch_ir = 16'h5000 + 16'(i); fetch_k = 16'h6000 + 16'(i);
    end
    cyc(); fetch_valid = 1'b0; hold_decode = 1'b1; dec_ready = 1'b1; #2;
    check("hold_dec_valid", 32'(dec_valid), 0);
    cyc(); #2;
    check("hold_occupancy", 32'(occupancy), 3);
    cyc(); hold_decode = 1'b0; dec_ready = 1'b0; flush = 1'b1;
    fetch_valid = 1'b1; fetch_ir = 16'h7777; fetch_k = 16'h7777; #2;
    check("flush_fetch_ready", 32'(fetch_ready), 0);
    cyc(); flush = 1'b0; fetch_valid = 1'b0; #2;
    check("flush_occupancy", 32'(occupancy), 0);
    check("flush_dec_valid", 32'(dec_valid), 0);
    check("flush_ir_low", 32'(ir_low), 0);

    // Reset mid-operation: queue emptied, no push on the reset edge
    cyc(); fetch_valid = 1'b1; fetch_ir = 16'h1357; fetch_k = 16'h2468;
    cyc(); a_rst = 1'b1; fetch_ir = 16'h8888; fetch_k = 16'h8888;
    cyc(); a_rst = 1'b0; fetch_valid = 1'b0; #2;
    check("midrst_occupancy", 32'(occupancy), 0);
    cyc(); fetch_valid = 1'b1; fetch_ir = 16'h6006; fetch_k = 16'h7007; dec_ready = 1'b1;
    expect_word(16'h6006, 16'h7007, 1'b0);
    cyc(); fetch_valid = 1'b0;
    cyc(); dec_ready = 1'b0; #2;
    check("midrst_after_occ", 32'(occupancy), 0);

`ifdef IR_FEED_BYPASS_EN
    cyc(); fetch_valid = 1'b1; fetch_ir = 16'h4242; fetch_k = 16'h5151; dec_ready = 1'b1;
    expect_word(16'h4242, 16'h5151, 1'b0);
    #2;
    check("byp_dec_valid", 32'(dec_valid), 1);
    check("byp_dec_ir", 32'(dec_ir), 32'h4242);
    check("byp_ir_low", 32'(ir_low), 32'h42);
    cyc(); fetch_valid = 1'b0; dec_ready = 1'b0; #2;
    check("byp_occupancy", 32'(occupancy), 0);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_feed.md
# ir_feed

Instruction feed stage between the fetch unit and the decoder, directly downstream of `cpu_status`. It buffers fetched instruction words, each a 16-bit IR plus a 16-bit K operand, in a small prefetch queue. When `cpu_status` requests it, the block substitutes the injected interrupt/JSR words for the queue head. It returns `feed_ack` and the head `ir_low` to `cpu_status`, closing its sequencing loop.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `a_rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  discard all queued words (branch redirect).
- `fetch_valid`  in  1  fetch word offered.
- `fetch_ir`  in  16  fetched IR.
- `fetch_k`  in  16  fetched K.
- `fetch_ready`  out  1  queue accepts a word this cycle.
- `int_ir`, `int_k`  in  16 each  injected words from `cpu_status`.
- `replace_ir`, `replace_k`, `hold_fetch`, `hold_decode`  in  1 each  controls from `cpu_status`.
- `feed_ack`  out  1  injected word consumed by decode.
- `ir_low`  out  8  `head_ir[7:0]`; 0 when the queue is empty.
- `dec_valid`  out  1  word presented to the decoder.
- `dec_ir`, `dec_k`  out  16 each  presented word.
- `dec_injected`  out  1  presented IR is injected.
- `dec_ready`  in  1  decoder accepts the word.
- `occupancy`  out  log2(DEPTH)+1  queued entries.

## Operation
- Storage is a circular buffer of {ir,k} with read pointer, write pointer and an occupancy counter covering 0..DEPTH. Pointers wrap modulo DEPTH.
- `fetch_ready = (occupancy != DEPTH) & ~hold_fetch & ~flush`.
- Push: `fetch_valid & fetch_ready`.
- Presentation:
  - `dec_ir = replace_ir ? int_ir : head_ir`.
  - `dec_k = replace_k ? int_k : head_k`.
  - `dec_injected = replace_ir`.
- `dec_valid = replace_ir | (~hold_decode & occupancy != 0)`.
- Accept: `dec_valid & dec_ready`.
- Pop on accept when either:
  - `~replace_ir` (normal word), or
  - `replace_ir & ~replace_k & occupancy != 0`: the JSR jump word carries the queued JSR's own K, which consumes that entry.
- Pop is suppressed whenever `occupancy == 0`.
- `feed_ack = replace_ir & dec_ready`. It is combinational and is sampled by `cpu_status` on the same edge.
- Push and pop in the same cycle leave occupancy unchanged; both pointers advance.
- `flush`:
  - Next cycle: occupancy = 0 and rptr = wptr = 0.
  - Overrides push and pop in the same cycle.
  - Injection (`replace_ir` path) and `feed_ack` are unaffected.
- Reset: pointers and occupancy cleared. Stored data is not cleared and is don't-care.

## Timing
- Outputs with all inputs low after reset: `dec_valid`=0, `fetch_ready`=1, `occupancy`=0, `feed_ack`=0, `dec_injected`=0, `ir_low`=0, `dec_ir`/`dec_k` don't-care.
- `a_rst` mid-operation: the next edge empties the queue, and the reset edge performs no push or pop. Injection paths stay combinational and follow their inputs.
- Queue latency: a word pushed at edge N is presented from cycle N+1 (bypass disabled).
- `cpu_status` control inputs act on this block's outputs combinationally in the same cycle. No injection state is held here.
- Full: `fetch_ready`=0 even if a pop occurs that cycle, so there is no push-on-pop when full.
- Empty with `replace_ir`: the injected word is still presented. A `replace_ir & ~replace_k` accept does not pop.
- `hold_decode` without `replace_ir`: `dec_valid`=0 and the queue holds.

## Configuration
- Macro: `IR_FEED_BYPASS_EN`.
- Defined: when `occupancy==0 & fetch_valid & ~hold_decode & ~replace_ir & ~flush`:
  - `dec_valid`=1 and `dec_ir`/`dec_k` = `fetch_ir`/`fetch_k`, with zero latency.
  - If `dec_ready`, the word is consumed and not stored. Otherwise it is pushed as normal.
  - `ir_low` follows `fetch_ir[7:0]` in that case.
- Undefined: no bypass; minimum one-cycle latency.

## Test plan
- Reset, then push 0x1111/0xAAAA, 0x2222/0xBBBB with `dec_ready`=1 → decoder receives them in order, one cycle after each push; `occupancy` returns to 0.
- Push 4 words with `dec_ready`=0 → `occupancy`=4 and `fetch_ready`=0. A 5th `fetch_valid` is ignored. Releasing `dec_ready` drains 4 words in order, exercising pointer wrap.
- Queue holds JSR 0x00F0/0x1234. Drive `replace_ir`=1, `replace_k`=1, `int_ir`=0x8322, `int_k`=0x0001 → `dec_ir`=0x8322, `dec_k`=0x0001, `feed_ack`=1, no pop. Then drive `replace_ir`=1, `replace_k`=0 → `dec_k`=0x1234, and the entry pops.
- Empty queue with `replace_ir`=`replace_k`=1, `int_k`=0xFFFE → injected word presented, `occupancy` stays 0, `feed_ack`=`dec_ready`.
- 3 queued words, `flush` together with `fetch_valid` → `occupancy`=0 next cycle and the fetch word is dropped.
- With `IR_FEED_BYPASS_EN`: empty queue, `fetch_valid` with 0x4242, `dec_ready`=1 → `dec_ir`=0x4242 in the same cycle and `occupancy` stays 0.
